// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its neighbours.
//   XLEN          data/address width
//   ILEN          instruction word width (also used by the decode stage)
//   RESET_PC      first fetch address after reset
//   QDEPTH        instruction queue depth and fetch credit limit
//   fetch_entry_t one queued instruction: {pc, inst}
package inst_fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam int QDEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Bundle of the fetch stage's handshake channels.
//   imem_req_*   fetch request toward instruction memory (valid/ready)
//   imem_rsp_*   in-order memory response (valid only, always accepted)
//   inst*        queue head toward the core (valid/ready)
//   redirect_*   flush and restart fetch at a new PC
// master: the fetch stage. slave: the memory/core environment.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush, used for both the instruction queue and the
// in-flight PC FIFO of the fetch stage.
//   clk, rst    clock, asynchronous active-low reset
//   push/data   write an entry (ignored when full unless popping too)
//   pop         remove the head entry (ignored when empty)
//   flush       empty the FIFO; overrides push and pop
//   head        entry at the head (meaningful while !empty)
//   count       number of stored entries; empty/full flags
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; pointers and count define which
  // entries are valid, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage in front of the single-cycle core.
// Issues sequential word-aligned fetches, keeps (queue + outstanding) within
// QDEPTH credits, queues in-order responses with their PCs, and hands
// {inst, inst_pc} to the core. A redirect flushes the queue, forgets the PCs
// of in-flight fetches and marks their responses to be dropped.
//   clk, rst   clock, asynchronous active-low reset
//   bus        inst_fetch_if.master (memory request/response, core, redirect)
module inst_fetch
  import inst_fetch_pkg::*;
(
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   pc_count;
  logic            started;
  logic            credit_ok;
  logic            issue;
  logic            rsp_keep;
  logic            deliver;
  logic            q_empty;
  logic            q_full;
  logic            pc_empty;
  logic            pc_full;
  logic [XLEN-1:0] pc_head;
  fetch_entry_t    q_head;
  fetch_entry_t    q_push_entry;

  // Every queued or in-flight instruction holds one credit.
  assign credit_ok = ({1'b0, q_count} + {1'b0, outstanding}) < (CW+1)'(QDEPTH);

  // started keeps the request low while reset is asserted.
  assign bus.imem_req_valid = started & credit_ok & ~bus.redirect_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign issue              = bus.imem_req_valid & bus.imem_req_ready;

  // Responses owed to fetches issued before a redirect are discarded.
  assign rsp_keep = bus.imem_rsp_valid & (drop_cnt == '0) & ~bus.redirect_valid;

  assign bus.inst_valid = ~q_empty;
  assign bus.inst       = bus.inst_valid ? q_head.inst : '0;
  assign bus.inst_pc    = bus.inst_valid ? q_head.pc   : '0;
  assign deliver        = bus.inst_valid & bus.inst_ready;

  assign q_push_entry = '{pc: pc_head, inst: bus.imem_rsp_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started     <= 1'b0;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      started <= 1'b1;

      if (bus.redirect_valid)
        fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      else if (issue)
        fetch_pc <= fetch_pc + XLEN'(4);

      // Dropped responses still retire an outstanding fetch.
      outstanding <= outstanding + CW'(issue) - CW'(bus.imem_rsp_valid);

      // Recomputed on every redirect, so the last of back-to-back redirects wins.
      if (bus.redirect_valid)
        drop_cnt <= outstanding - CW'(bus.imem_rsp_valid);
      else if (bus.imem_rsp_valid && drop_cnt != '0)
        drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_queue #(.DEPTH(QDEPTH), .WIDTH(XLEN)) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .flush     (bus.redirect_valid),
    .head      (pc_head),
    .count     (pc_count),
    .empty     (pc_empty),
    .full      (pc_full)
  );

  fetch_queue #(.DEPTH(QDEPTH), .WIDTH($bits(fetch_entry_t))) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data (q_push_entry),
    .pop       (deliver),
    .flush     (bus.redirect_valid),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  // The credit rule makes these unreachable with a well-behaved memory.
  rsp_into_full_queue: assert property (@(posedge clk) disable iff (!rst)
    !(rsp_keep && q_full));
  rsp_without_pc: assert property (@(posedge clk) disable iff (!rst)
    !(rsp_keep && pc_empty));
  issue_into_full_pc_fifo: assert property (@(posedge clk) disable iff (!rst)
    !(issue && pc_full));
  inflight_accounting: assert property (@(posedge clk) disable iff (!rst)
    (pc_count + drop_cnt) == outstanding);

endmodule
